// File: rtl/ssb_pkg.sv
// Shared constants for the SS/PBCH block generator: m-sequence tables,
// legal cell-ID bounds, SSB symbol indices and FSM states.
package ssb_pkg;

  localparam int N_ID_1_MAX = 335;
  localparam int N_ID_2_MAX = 2;

  typedef enum logic [1:0] {
    SYM_PSS   = 2'd0,
    SYM_PBCH0 = 2'd1,
    SYM_SSS   = 2'd2,
    SYM_PBCH1 = 2'd3
  } ssb_sym_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2
  } ssb_state_e;

  // Bit i of the result is x(i). tap1 selects x(i+1) feedback instead of x(i+4).
  function automatic logic [126:0] gen_mseq(input logic [6:0] init, input bit tap1);
    logic [126:0] x;
    x      = '0;
    x[6:0] = init;
    for (int i = 0; i < 120; i++)
      x[i+7] = (tap1 ? x[i+1] : x[i+4]) ^ x[i];
    return x;
  endfunction

  localparam logic [126:0] XP = gen_mseq(7'b1110110, 1'b0);
  localparam logic [126:0] X0 = gen_mseq(7'b0000001, 1'b0);
  localparam logic [126:0] X1 = gen_mseq(7'b0000001, 1'b1);

endpackage

// File: rtl/mod127_ptr.sv
// Loadable, enabled modulo-127 counter used as an m-sequence read pointer.
module mod127_ptr (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       en_i,
  output logic [6:0] ptr_o
);

  logic [6:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i)    ptr_d = load_val_i;
    else if (en_i) ptr_d = (ptr_q == 7'd126) ? 7'd0 : ptr_q + 7'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) ptr_q <= '0;
    else           ptr_q <= ptr_d;

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ssb_tx_gen.sv
// Frequency-domain SSB grid generator: PSS on symbol 0, SSS on symbol 2,
// zero PBCH symbols, FFT_LEN bins per symbol in natural FFT order.
module ssb_tx_gen
  import ssb_pkg::*;
#(
  parameter int NFFT   = 8,
  parameter int OUT_DW = 32,
  parameter int AMP    = 8192
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [8:0]        N_id_1_i,
  input  logic [1:0]        N_id_2_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic [1:0]        m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready
);

  localparam int HW = OUT_DW / 2;
  localparam logic [HW-1:0] AMP_P = HW'(AMP);
  localparam logic [HW-1:0] AMP_N = HW'(-AMP);

  ssb_state_e state_q, state_d;
  logic [8:0]      id1_q, id1_d;
  logic [1:0]      id2_q, id2_d;
  logic [NFFT-1:0] b_q, b_d;
  logic [1:0]      s_q, s_d;
  logic            err_q, err_d;

  logic            id_ok, hs, last_bin, active;
  logic [NFFT-1:0] n_idx;
  logic [2:0][6:0] base, ptr;
  logic [8:0]      sub, m1, m1p;
  logic [6:0]      m0_base;

  assign id_ok    = (N_id_1_i <= 9'(N_ID_1_MAX)) && (N_id_2_i <= 2'(N_ID_2_MAX));
  assign hs       = (state_q == ST_RUN) && m_axis_out_tready;
  assign last_bin = (b_q == {NFFT{1'b1}});
  assign n_idx    = b_q + NFFT'(64);
  assign active   = (n_idx <= NFFT'(126));

  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i && id_ok) state_d = ST_CALC;
      ST_CALC: state_d = ST_RUN;
      ST_RUN:  if (hs && last_bin && s_q == 2'd3) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id1_d = id1_q;
    id2_d = id2_q;
    b_d   = b_q;
    s_d   = s_q;
    err_d = (state_q == ST_IDLE) && start_i && !id_ok;
    if (state_q == ST_IDLE && start_i && id_ok) begin
      id1_d = N_id_1_i;
      id2_d = N_id_2_i;
    end
    if (state_q == ST_CALC) begin
      b_d = '0;
      s_d = '0;
    end
    if (hs) begin
      b_d = b_q + NFFT'(1);
      if (last_bin) s_d = s_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      id1_q <= '0;
      id2_q <= '0;
      b_q   <= '0;
      s_q   <= '0;
      err_q <= 1'b0;
    end else begin
      id1_q <= id1_d;
      id2_q <= id2_d;
      b_q   <= b_d;
      s_q   <= s_d;
      err_q <= err_d;
    end

  // Pointers start each symbol at n=64 (bin 0); 127 increments per symbol
  // bring them back to the same value, so one load per SSB suffices.
  always_comb begin
    sub     = 9'd0;
    m0_base = 7'd0;
    if (id1_q >= 9'd224) begin
      sub     = 9'd224;
      m0_base = 7'd30;
    end else if (id1_q >= 9'd112) begin
      sub     = 9'd112;
      m0_base = 7'd15;
    end
    m1  = id1_q - sub;
    m1p = m1 + 9'd64;
    if (m1p >= 9'd127) m1p = m1p - 9'd127;
    base[0] = m0_base + 7'({id2_q, 2'b00}) + 7'(id2_q) + 7'd64;
    base[1] = m1p[6:0];
    case (id2_q)
      2'd1:    base[2] = 7'd107;
      2'd2:    base[2] = 7'd23;
      default: base[2] = 7'd64;
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_ptr
    mod127_ptr u_ptr (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .load_i     (state_q == ST_CALC),
      .load_val_i (base[i]),
      .en_i       (hs && active),
      .ptr_o      (ptr[i])
    );
  end

  always_comb begin
    m_axis_out_tvalid = (state_q == ST_RUN);
    busy_o            = (state_q != ST_IDLE);
    err_o             = err_q;
    m_axis_out_tuser  = (state_q == ST_RUN) ? s_q : 2'd0;
    m_axis_out_tlast  = (state_q == ST_RUN) && last_bin;
    m_axis_out_tdata  = '0;
    if (state_q == ST_RUN && active) begin
      if (s_q == SYM_PSS)
        m_axis_out_tdata = {{HW{1'b0}}, (XP[ptr[2]] ? AMP_N : AMP_P)};
      else if (s_q == SYM_SSS)
        m_axis_out_tdata = {{HW{1'b0}}, ((X0[ptr[0]] ^ X1[ptr[1]]) ? AMP_N : AMP_P)};
    end
  end

endmodule

// File: tb/tb_ssb_tx_gen.sv
// Directed bench for ssb_tx_gen: hand vectors plus an index-arithmetic model.
module tb_ssb_tx_gen;

  localparam int FFT_LEN = 256;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [8:0]  N_id_1_i = '0;
  logic [1:0]  N_id_2_i = '0;
  logic        busy_o, err_o;
  logic [31:0] m_axis_out_tdata;
  logic [1:0]  m_axis_out_tuser;
  logic        m_axis_out_tlast, m_axis_out_tvalid;
  logic        m_axis_out_tready = 1'b1;

  ssb_tx_gen #(.NFFT(8), .OUT_DW(32), .AMP(8192)) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .start_i           (start_i),
    .N_id_1_i          (N_id_1_i),
    .N_id_2_i          (N_id_2_i),
    .busy_o            (busy_o),
    .err_o             (err_o),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tuser  (m_axis_out_tuser),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tready (m_axis_out_tready)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  bit xp[127], x0s[127], x1s[127];
  logic [31:0] cap [FFT_LEN*4];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [34:0] exp_beat(input int id1, input int id2, input int s, input int b);
    int n, q, m0, m1, mp;
    logic [15:0] re;
    n  = (b + 64) % FFT_LEN;
    q  = id1 / 112;
    m0 = 15 * q + 5 * id2;
    m1 = id1 % 112;
    mp = (43 * id2) % 127;
    re = 16'h0;
    if (n <= 126 && s == 0)
      re = xp[(n + mp) % 127] ? 16'hE000 : 16'h2000;
    else if (n <= 126 && s == 2)
      re = (x0s[(n + m0) % 127] ^ x1s[(n + m1) % 127]) ? 16'hE000 : 16'h2000;
    return {2'(s), (b == FFT_LEN - 1), 16'h0, re};
  endfunction

  function automatic logic [37:0] outs_now();
    return {busy_o, err_o, m_axis_out_tvalid, m_axis_out_tlast, m_axis_out_tuser, m_axis_out_tdata};
  endfunction

  task automatic run_ssb(input int id1, input int id2, input bit rnd, input int inj_at, input int abort_at);
    int beat = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] prev = '0;
    N_id_1_i = 9'(id1);
    N_id_2_i = 2'(id2);
    start_i  = 1'b1;
    step;
    start_i = 1'b0;
    chk("busy_no_valid_t1", {busy_o, m_axis_out_tvalid}, 2'b10);
    step;
    chk("first_tvalid_t2", m_axis_out_tvalid, 1'b1);
    while (beat < FFT_LEN * 4 && cyc < 4000) begin
      if (beat == abort_at) begin
        reset_ni = 1'b0;
        #1;
        chk("async_reset_outs", outs_now(), '0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        step;
        chk("idle_after_abort", {busy_o, m_axis_out_tvalid}, 2'b00);
        return;
      end
      if (inj_at >= 0 && beat == inj_at) begin
        start_i  = 1'b1;
        N_id_1_i = 9'd5;
        N_id_2_i = 2'd1;
      end
      m_axis_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("tvalid_in_run", m_axis_out_tvalid, 1'b1);
      if (stalled) chk("stall_stable", m_axis_out_tdata, prev);
      if (m_axis_out_tready) begin
        chk($sformatf("beat%0d", beat), {m_axis_out_tuser, m_axis_out_tlast, m_axis_out_tdata},
            exp_beat(id1, id2, beat / FFT_LEN, beat % FFT_LEN));
        cap[beat] = m_axis_out_tdata;
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = m_axis_out_tdata;
      end
      step;
      start_i = 1'b0;
      cyc++;
      if (inj_at >= 0) chk("no_err_in_run", err_o, 1'b0);
    end
    m_axis_out_tready = 1'b1;
    chk("beats_done", beat, FFT_LEN * 4);
    chk("idle_after_ssb", {busy_o, m_axis_out_tvalid}, 2'b00);
  endtask

  initial begin
    logic [6:0] r;
    logic [31:0] acc;
    // m-sequences, bench-side copy
    r = 7'b1110110;
    for (int i = 0; i < 127; i++) begin
      xp[i] = r[0];
      r = {r[4] ^ r[0], r[6:1]};
    end
    r = 7'b0000001;
    for (int i = 0; i < 127; i++) begin
      x0s[i] = r[0];
      r = {r[4] ^ r[0], r[6:1]};
    end
    r = 7'b0000001;
    for (int i = 0; i < 127; i++) begin
      x1s[i] = r[0];
      r = {r[1] ^ r[0], r[6:1]};
    end

    #12;
    chk("reset_outs", outs_now(), '0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step;

    run_ssb(0, 0, 1'b0, -1, -1);
    chk("pss_bin192", cap[192], 32'h0000_2000);
    chk("pss_bin193", cap[193], 32'h0000_E000);
    chk("sss_bin192", cap[512 + 192], 32'h0000_2000);
    chk("sss_bin193", cap[512 + 193], 32'h0000_2000);
    acc = '0;
    for (int b = 63; b <= 191; b++) acc |= cap[b] | cap[512 + b];
    for (int b = 0; b < FFT_LEN; b++) acc |= cap[256 + b] | cap[768 + b];
    chk("zero_bins", acc, 32'h0);

    run_ssb(335, 2, 1'b0, -1, -1);
    run_ssb(335, 2, 1'b1, -1, -1);
    run_ssb(120, 1, 1'b1, 100, -1);

    N_id_1_i = 9'd336;
    N_id_2_i = 2'd0;
    start_i  = 1'b1;
    step;
    start_i = 1'b0;
    chk("err_pulse_id1", {err_o, busy_o, m_axis_out_tvalid}, 3'b100);
    step;
    chk("err_clear_id1", {err_o, busy_o, m_axis_out_tvalid}, 3'b000);
    N_id_1_i = 9'd10;
    N_id_2_i = 2'd3;
    start_i  = 1'b1;
    step;
    start_i = 1'b0;
    chk("err_pulse_id2", {err_o, busy_o, m_axis_out_tvalid}, 3'b100);
    step;
    chk("err_clear_id2", {err_o, busy_o, m_axis_out_tvalid}, 3'b000);

    run_ssb(200, 1, 1'b0, -1, 300);
    run_ssb(200, 1, 1'b0, -1, -1);
    run_ssb(7, 0, 1'b1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
